// File: rtl/hazard_tracker_pkg.sv
// ============================================================================
//  Module   : hazard_tracker_pkg
//  Purpose  : Shared types, select encodings and helpers for the hazard tracker.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package hazard_tracker_pkg;

  localparam int REC_AW = 5;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  // a3 is forced to 0 for non-writers so the record matches nothing
  typedef struct packed {
    logic [REC_AW-1:0] a3;
    logic [1:0]        tnew;
    logic [REC_AW-1:0] rs;
    logic [REC_AW-1:0] rt;
  } stage_rec_t;

  function automatic logic [1:0] satdec(input logic [1:0] x);
    return (x == 2'd0) ? 2'd0 : x - 2'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_match.sv
// ============================================================================
//  Module   : hazard_match
//  Purpose  : Compares one source register against one in-flight stage record.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_match
  import hazard_tracker_pkg::*;
#(
  parameter int REG_AW = REC_AW
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] a3,
  input  logic [1:0]        tnew,
  input  logic [1:0]        t_use,
  output logic              match,
  output logic              ready,
  output logic              late
);

  // $0 is hard-wired, so it never matches a producer
  assign match = (src != '0) && (a3 == src);
  assign ready = (tnew == 2'd0);
  assign late  = (tnew > t_use);

endmodule

`default_nettype wire

// File: rtl/hazard_tracker.sv
// ============================================================================
//  Module   : hazard_tracker
//  Purpose  : E/M/W destination scoreboard producing decode stall and bypass selects.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_tracker
  import hazard_tracker_pkg::*;
#(
  parameter int         REG_AW    = REC_AW,
  parameter logic [1:0] TUSE_NONE = hazard_tracker_pkg::TUSE_NONE
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [REG_AW-1:0] a3_d,
  input  logic              regwrite_d,
  input  logic [1:0]        t_use_rs_d,
  input  logic [1:0]        t_use_rt_d,
  input  logic [1:0]        t_new_d,
  output logic              stall,
  output logic [1:0]        fwd_rs_d,
  output logic [1:0]        fwd_rt_d,
  output logic [1:0]        fwd_rs_e,
  output logic [1:0]        fwd_rt_e,
  output logic              fwd_rt_m
);

  stage_rec_t r_e;
  stage_rec_t r_m;
  stage_rec_t r_w;

  logic              w_stall;
  logic [REG_AW-1:0] w_a3   [3];
  logic [1:0]        w_tnew [3];
  logic [REG_AW-1:0] w_d_src  [2];
  logic [1:0]        w_d_tuse [2];
  logic [REG_AW-1:0] w_e_src  [2];

  wire  [2:0]        w_d_hit  [2];
  wire  [2:0]        w_d_rdy  [2];
  wire  [2:0]        w_d_late [2];
  wire  [1:0]        w_e_hit  [2];
  wire  [1:0]        w_e_rdy  [2];
  wire  [1:0]        w_e_late [2];
  logic              w_m_hit;
  logic              w_m_rdy;
  logic              w_m_late;

  logic [1:0]        w_stall_src [2];
  logic [1:0]        w_fwd_d     [2];
  logic [1:0]        w_fwd_e     [2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_e <= '0;
      r_m <= '0;
      r_w <= '0;
    end else begin
      if (w_stall) begin
        r_e <= '0;
      end else begin
        r_e.a3   <= regwrite_d ? a3_d : '0;
        r_e.tnew <= satdec(t_new_d);
        r_e.rs   <= rs_d;
        r_e.rt   <= rt_d;
      end
      r_m.a3   <= r_e.a3;
      r_m.tnew <= satdec(r_e.tnew);
      r_m.rs   <= r_e.rs;
      r_m.rt   <= r_e.rt;
      r_w.a3   <= r_m.a3;
      r_w.tnew <= satdec(r_m.tnew);
      r_w.rs   <= '0;
      r_w.rt   <= '0;
    end
  end

  assign w_a3[0]     = r_e.a3;
  assign w_a3[1]     = r_m.a3;
  assign w_a3[2]     = r_w.a3;
  assign w_tnew[0]   = r_e.tnew;
  assign w_tnew[1]   = r_m.tnew;
  assign w_tnew[2]   = r_w.tnew;
  assign w_d_src[0]  = rs_d;
  assign w_d_src[1]  = rt_d;
  assign w_d_tuse[0] = t_use_rs_d;
  assign w_d_tuse[1] = t_use_rt_d;
  assign w_e_src[0]  = r_e.rs;
  assign w_e_src[1]  = r_e.rt;

  // Decode sources against E (0), M (1) and W (2)
  generate
    for (genvar s = 0; s < 2; s++) begin : g_d_src
      for (genvar g = 0; g < 3; g++) begin : g_d_stg
        hazard_match #(.REG_AW(REG_AW)) u_match (
          .src   (w_d_src[s]),
          .a3    (w_a3[g]),
          .tnew  (w_tnew[g]),
          .t_use (w_d_tuse[s]),
          .match (w_d_hit[s][g]),
          .ready (w_d_rdy[s][g]),
          .late  (w_d_late[s][g])
        );
      end
    end

    // Execute sources against M (0) and W (1)
    for (genvar s = 0; s < 2; s++) begin : g_e_src
      for (genvar g = 0; g < 2; g++) begin : g_e_stg
        hazard_match #(.REG_AW(REG_AW)) u_match (
          .src   (w_e_src[s]),
          .a3    (w_a3[g+1]),
          .tnew  (w_tnew[g+1]),
          .t_use (2'd0),
          .match (w_e_hit[s][g]),
          .ready (w_e_rdy[s][g]),
          .late  (w_e_late[s][g])
        );
      end
    end
  endgenerate

  hazard_match #(.REG_AW(REG_AW)) u_match_m_rt (
    .src   (r_m.rt),
    .a3    (r_w.a3),
    .tnew  (r_w.tnew),
    .t_use (2'd0),
    .match (w_m_hit),
    .ready (w_m_rdy),
    .late  (w_m_late)
  );

  // A younger match that is not ready blocks older stages; stall covers it
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      w_stall_src[s] = 2'd0;
      w_fwd_d[s]     = FWD_RF;
      w_fwd_e[s]     = FWD_RF;
      w_stall_src[s][0] = (w_d_tuse[s] != TUSE_NONE) &&
                          ((w_d_hit[s][0] && w_d_late[s][0]) ||
                           (w_d_hit[s][1] && w_d_late[s][1]));
      if (w_d_hit[s][0]) begin
        w_fwd_d[s] = w_d_rdy[s][0] ? FWD_E : FWD_RF;
      end else if (w_d_hit[s][1]) begin
        w_fwd_d[s] = w_d_rdy[s][1] ? FWD_M : FWD_RF;
      end else if (w_d_hit[s][2]) begin
        w_fwd_d[s] = FWD_W;
      end
      if (w_e_hit[s][0] && w_e_rdy[s][0]) begin
        w_fwd_e[s] = FWD_M;
      end else if (w_e_hit[s][1]) begin
        w_fwd_e[s] = FWD_W;
      end
    end
  end

  assign w_stall  = w_stall_src[0][0] | w_stall_src[1][0];
  assign stall    = w_stall;
  assign fwd_rs_d = w_fwd_d[0];
  assign fwd_rt_d = w_fwd_d[1];
  assign fwd_rs_e = w_fwd_e[0];
  assign fwd_rt_e = w_fwd_e[1];
  assign fwd_rt_m = w_m_hit;

  logic w_unused;
  assign w_unused = ^{w_d_rdy[0][2], w_d_rdy[1][2], w_d_late[0][2], w_d_late[1][2],
                      w_e_late[0], w_e_late[1], w_e_rdy[0][1], w_e_rdy[1][1],
                      w_m_rdy, w_m_late, r_m.rs, r_w.rs, r_w.rt,
                      w_stall_src[0][1], w_stall_src[1][1]};

endmodule

`default_nettype wire

// File: tb/tb_hazard_tracker.sv
// ============================================================================
//  Module   : tb_hazard_tracker
//  Purpose  : Directed scoreboard bench for the hazard tracker.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_tracker;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] rs_d = '0;
  logic [4:0] rt_d = '0;
  logic [4:0] a3_d = '0;
  logic       regwrite_d = 1'b0;
  logic [1:0] t_use_rs_d = 2'd3;
  logic [1:0] t_use_rt_d = 2'd3;
  logic [1:0] t_new_d = 2'd1;
  logic       stall;
  logic [1:0] fwd_rs_d;
  logic [1:0] fwd_rt_d;
  logic [1:0] fwd_rs_e;
  logic [1:0] fwd_rt_e;
  logic       fwd_rt_m;

  typedef struct packed {
    int         id;
    logic       st;
    logic [1:0] rsd;
    logic [1:0] rtd;
    logic [1:0] rse;
    logic [1:0] rte;
    logic       rtm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_id = 0;

  hazard_tracker dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rs_d       (rs_d),
    .rt_d       (rt_d),
    .a3_d       (a3_d),
    .regwrite_d (regwrite_d),
    .t_use_rs_d (t_use_rs_d),
    .t_use_rt_d (t_use_rt_d),
    .t_new_d    (t_new_d),
    .stall      (stall),
    .fwd_rs_d   (fwd_rs_d),
    .fwd_rt_d   (fwd_rt_d),
    .fwd_rs_e   (fwd_rs_e),
    .fwd_rt_e   (fwd_rt_e),
    .fwd_rt_m   (fwd_rt_m)
  );

  always #5 clk = ~clk;

  function automatic void chk(input int id, input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL vec%0d %s: got %0d, expected %0d", id, name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.id, "stall",    int'(stall),    int'(e.st));
      chk(e.id, "fwd_rs_d", int'(fwd_rs_d), int'(e.rsd));
      chk(e.id, "fwd_rt_d", int'(fwd_rt_d), int'(e.rtd));
      chk(e.id, "fwd_rs_e", int'(fwd_rs_e), int'(e.rse));
      chk(e.id, "fwd_rt_e", int'(fwd_rt_e), int'(e.rte));
      chk(e.id, "fwd_rt_m", int'(fwd_rt_m), int'(e.rtm));
    end
  end

  // One decode-stage vector per cycle plus the outputs expected during that cycle
  task automatic drive(input logic rst, input int rs, input int rt, input int a3,
                       input logic rw, input int tur, input int tut, input int tn,
                       input logic e_st, input int e_rsd, input int e_rtd,
                       input int e_rse, input int e_rte, input logic e_rtm);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n    = rst;
    rs_d       = rs[4:0];
    rt_d       = rt[4:0];
    a3_d       = a3[4:0];
    regwrite_d = rw;
    t_use_rs_d = tur[1:0];
    t_use_rt_d = tut[1:0];
    t_new_d    = tn[1:0];
    e.id  = vec_id;
    e.st  = e_st;
    e.rsd = e_rsd[1:0];
    e.rtd = e_rtd[1:0];
    e.rse = e_rse[1:0];
    e.rte = e_rte[1:0];
    e.rtm = e_rtm;
    q.push_back(e);
    vec_id++;
  endtask

  task automatic nop(input int e_rse, input int e_rte, input logic e_rtm);
    drive(1, 0, 0, 0, 0, 3, 3, 1, 0, 0, 0, e_rse, e_rte, e_rtm);
  endtask

  initial begin
    // reset, then async reset with $5 in flight in E
    drive(0, 0, 0, 0, 0, 3, 3, 1,  0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 5, 1, 3, 3, 2,  0, 0, 0, 0, 0, 0);
    drive(0, 5, 0, 0, 0, 0, 3, 1,  0, 0, 0, 0, 0, 0);
    drive(1, 5, 0, 0, 0, 1, 3, 1,  0, 0, 0, 0, 0, 0);
    nop(0, 0, 0);
    // ALU result consumed by beq
    drive(1, 1, 2, 3, 1, 1, 1, 2,  0, 0, 0, 0, 0, 0);
    drive(1, 3, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
    drive(1, 3, 0, 0, 0, 0, 0, 1,  0, 2, 0, 0, 0, 0);
    // load-use; the beq in E takes the addu from W meanwhile
    drive(1, 6, 4, 4, 1, 1, 3, 3,  0, 0, 0, 3, 0, 0);
    drive(1, 4, 8, 8, 1, 1, 3, 2,  1, 0, 0, 0, 0, 0);
    drive(1, 4, 8, 8, 1, 1, 3, 2,  0, 0, 0, 0, 0, 0);
    // jal then jr $31
    drive(1, 0, 0, 31, 1, 3, 3, 1, 0, 0, 0, 3, 0, 0);
    drive(1, 31, 0, 0, 0, 0, 3, 1, 0, 1, 0, 0, 0, 0);
    nop(2, 0, 0);
    // E and M both write $7
    drive(1, 1, 2, 7, 1, 1, 1, 2,  0, 0, 0, 0, 0, 0);
    drive(1, 1, 2, 7, 1, 1, 1, 2,  0, 0, 0, 0, 0, 0);
    drive(1, 7, 0, 10, 1, 1, 3, 2, 0, 0, 0, 0, 0, 0);
    drive(1, 7, 0, 0, 0, 1, 3, 1,  0, 2, 0, 2, 0, 0);
    nop(3, 0, 0);
    // writes to $0 and reads of $0
    drive(1, 1, 2, 0, 1, 1, 1, 2,  0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 5, 1, 1, 1, 2,  0, 0, 0, 0, 0, 0);
    // lw $9 then sw with rt = 9
    drive(1, 6, 9, 9, 1, 1, 3, 3,  0, 0, 0, 0, 0, 0);
    drive(1, 6, 9, 0, 0, 1, 2, 1,  0, 0, 0, 0, 0, 0);
    nop(0, 0, 0);
    nop(0, 0, 1);
    nop(0, 0, 0);
    // load then branch on both operands: two-cycle stall
    drive(1, 6, 12, 12, 1, 1, 3, 3, 0, 0, 0, 0, 0, 0);
    drive(1, 12, 12, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    drive(1, 12, 12, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    drive(1, 12, 12, 0, 0, 0, 0, 1, 0, 3, 3, 0, 0, 0);
    // rt paths in E and M
    drive(1, 1, 2, 13, 1, 1, 1, 2, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 13, 14, 1, 1, 1, 2, 0, 0, 0, 0, 0, 0);
    nop(0, 2, 0);
    nop(0, 0, 1);
    nop(0, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
